// File: rtl/pipeline_stall_controller.sv
// Hazard/stall controller: load-use bubbles, branch flushes and
// memory-wait freezes, with a sticky memory timeout.
module pipeline_stall_controller #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_req_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pipe_hold_o,
    output logic             timeout_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrlState_e;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    ctrlState_e       state;
    ctrlState_e       stateNext;
    logic [7:0]       waitCnt;
    logic [7:0]       waitCntNext;
    logic [CNT_W-1:0] stallCnt;

    logic memStall;
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idExBubble;
    logic pipeHold;
    logic timeout;

    always_comb begin
        memStall    = mem_req_i & ~mem_ack_i;
        stateNext   = state;
        waitCntNext = waitCnt;
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExBubble  = 1'b0;
        pipeHold    = 1'b0;
        timeout     = 1'b0;

        unique case (state)
            RUN: begin
                if (memStall) begin
                    pcWrite     = 1'b0;
                    ifIdWrite   = 1'b0;
                    pipeHold    = 1'b1;
                    stateNext   = MEM_WAIT;
                    waitCntNext = 8'd1;
                end else if (stall_req_i) begin
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExBubble = 1'b1;
                end else if (branch_taken_i) begin
                    ifIdFlush = 1'b1;
                end
            end
            MEM_WAIT: begin
                pcWrite   = 1'b0;
                ifIdWrite = 1'b0;
                pipeHold  = 1'b1;
                // Ack on the limit cycle still wins over the timeout
                if (mem_ack_i) begin
                    stateNext   = RUN;
                    waitCntNext = 8'd0;
                end else if (waitCnt == LIMIT) begin
                    stateNext = ERROR;
                end else begin
                    waitCntNext = waitCnt + 8'd1;
                end
            end
            ERROR: begin
                pcWrite   = 1'b0;
                ifIdWrite = 1'b0;
                pipeHold  = 1'b1;
                timeout   = 1'b1;
            end
            default: begin
                pcWrite     = 1'b0;
                ifIdWrite   = 1'b0;
                pipeHold    = 1'b1;
                stateNext   = RUN;
                waitCntNext = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= RUN;
            waitCnt  <= 8'd0;
            stallCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (!pcWrite && stallCnt != '1) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
        end
    end

    // Reset forces a bubble into ID/EX regardless of the clock
    assign pc_write_o     = pcWrite & ~rst_i;
    assign if_id_write_o  = ifIdWrite & ~rst_i;
    assign if_id_flush_o  = ifIdFlush & ~rst_i;
    assign id_ex_bubble_o = idExBubble | rst_i;
    assign pipe_hold_o    = pipeHold & ~rst_i;
    assign timeout_o      = timeout & ~rst_i;
    assign state_o        = state;
    assign stall_cnt_o    = stallCnt;

endmodule
